// File: rtl/pc_redirect_ctrl.sv
`timescale 1ns/1ps
// pc_redirect_ctrl
//   Fetch-redirect controller. Arbitrates trap > branch > fence redirect
//   requests, holds the chosen target until fetch is ready, drives the
//   PC-set channel and the wrong-path flush window for fetch/decode.
//   Optional build macro: PCL_REDIRECT_ALIGN_CHK_EN
//     defined   : accepted targets with tgt[1:0] != 0 are acked but
//                 dropped, oMisalign pulses, no redirect/flush is started.
//     undefined : no alignment check, oMisalign tied low.
module pc_redirect_ctrl #(
   parameter int unsigned FLUSH_CYC = 1,
   parameter logic [31:0] RST_TGT   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        iTrapEn,
   input  logic [31:0] iTrapTgt,
   input  logic        iBrEn,
   input  logic [31:0] iBrTgt,
   input  logic        iFenceEn,
   input  logic [31:0] iFenceTgt,
   input  logic        iFetchRdy,
   output logic        oTrapAck,
   output logic        oBrAck,
   output logic        oFenceAck,
   output logic        oSetEn,
   output logic [31:0] oSetTgt,
   output logic        oFlush,
   output logic        oMisalign
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam logic [1:0] LP_FCNT_INIT = 2'(FLUSH_CYC - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [1:0]  r_fcnt;
   logic [1:0]  w_fcnt_nxt;
   logic [31:0] r_tgt;
   logic [31:0] w_tgt_nxt;

   logic        w_trap_ack;
   logic        w_br_ack;
   logic        w_fence_ack;
   logic        w_accept;
   logic [31:0] w_sel_tgt;
   logic        w_misalign;
   logic        w_load;

   // Fixed-priority arbitration; acks are gated by reset so they read 0 while rst is low
   always_comb begin
      w_trap_ack  = 1'b0;
      w_br_ack    = 1'b0;
      w_fence_ack = 1'b0;
      w_sel_tgt   = iTrapTgt;
      if (rst) begin
         if (iTrapEn) begin
            w_trap_ack = 1'b1;
            w_sel_tgt  = iTrapTgt;
         end else if (r_state == ST_IDLE) begin
            if (iBrEn) begin
               w_br_ack  = 1'b1;
               w_sel_tgt = iBrTgt;
            end else if (iFenceEn) begin
               w_fence_ack = 1'b1;
               w_sel_tgt   = iFenceTgt;
            end
         end
      end
   end

   assign w_accept = w_trap_ack | w_br_ack | w_fence_ack;

`ifdef PCL_REDIRECT_ALIGN_CHK_EN
   assign w_misalign = w_accept & (w_sel_tgt[1:0] != 2'b00);
`else
   assign w_misalign = 1'b0;
`endif

   assign w_load = w_accept & ~w_misalign;

   // Next-state, flush counter and target selection
   always_comb begin
      w_state_nxt = r_state;
      w_fcnt_nxt  = r_fcnt;
      w_tgt_nxt   = r_tgt;
      if (w_load) begin
         w_tgt_nxt = w_sel_tgt;
      end
      unique case (r_state)
         ST_IDLE: begin
            if (w_load) begin
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (w_accept) begin
               // a trap replaces the pending target; a dropped misaligned trap cancels it
               w_state_nxt = w_misalign ? ST_IDLE : ST_ISSUE;
            end else if (iFetchRdy) begin
               w_state_nxt = ST_FLUSH;
               w_fcnt_nxt  = LP_FCNT_INIT;
            end
         end
         ST_FLUSH: begin
            if (w_accept) begin
               w_state_nxt = w_misalign ? ST_IDLE : ST_ISSUE;
            end else if (r_fcnt == 2'd0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_fcnt_nxt = r_fcnt - 2'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, counter and target registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_fcnt  <= '0;
         r_tgt   <= RST_TGT;
      end else begin
         r_state <= w_state_nxt;
         r_fcnt  <= w_fcnt_nxt;
         r_tgt   <= w_tgt_nxt;
      end
   end

   assign oTrapAck  = w_trap_ack;
   assign oBrAck    = w_br_ack;
   assign oFenceAck = w_fence_ack;
   assign oSetEn    = (r_state == ST_ISSUE) & iFetchRdy;
   assign oSetTgt   = r_tgt;
   assign oFlush    = (r_state != ST_IDLE) | w_load;
   assign oMisalign = w_misalign;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for pc_redirect_ctrl: directed scenarios followed by
// random traffic, all compared against a redirect-level reference model.
module tb_pc_redirect_ctrl;

   localparam int unsigned TB_FLUSH_CYC = 1;
   localparam logic [31:0] TB_RST_TGT   = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        iTrapEn;
   logic [31:0] iTrapTgt;
   logic        iBrEn;
   logic [31:0] iBrTgt;
   logic        iFenceEn;
   logic [31:0] iFenceTgt;
   logic        iFetchRdy;
   logic        oTrapAck;
   logic        oBrAck;
   logic        oFenceAck;
   logic        oSetEn;
   logic [31:0] oSetTgt;
   logic        oFlush;
   logic        oMisalign;

   int unsigned n_total;
   int unsigned n_bad;

   // reference model: a pending redirect, the last accepted target, and
   // the number of post-issue flush cycles still owed
   bit          m_pend;
   logic [31:0] m_show;
   int          m_fleft;

   pc_redirect_ctrl #(
      .FLUSH_CYC(TB_FLUSH_CYC),
      .RST_TGT  (TB_RST_TGT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .iTrapEn  (iTrapEn),
      .iTrapTgt (iTrapTgt),
      .iBrEn    (iBrEn),
      .iBrTgt   (iBrTgt),
      .iFenceEn (iFenceEn),
      .iFenceTgt(iFenceTgt),
      .iFetchRdy(iFetchRdy),
      .oTrapAck (oTrapAck),
      .oBrAck   (oBrAck),
      .oFenceAck(oFenceAck),
      .oSetEn   (oSetEn),
      .oSetTgt  (oSetTgt),
      .oFlush   (oFlush),
      .oMisalign(oMisalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pend  = 1'b0;
      m_show  = TB_RST_TGT;
      m_fleft = 0;
   endtask

   // drive one cycle of inputs after the falling edge, check outputs, advance model
   task automatic step(input bit t, input logic [31:0] tt,
                       input bit b, input logic [31:0] bt,
                       input bit f, input logic [31:0] ft,
                       input bit r);
      bit          busy;
      bit          e_t;
      bit          e_b;
      bit          e_f;
      bit          acc;
      bit          mis;
      logic [31:0] sel;
      @(negedge clk);
      iTrapEn = t; iTrapTgt = tt;
      iBrEn = b;   iBrTgt = bt;
      iFenceEn = f; iFenceTgt = ft;
      iFetchRdy = r;
      #1;
      busy = m_pend || (m_fleft > 0);
      e_t  = t;
      e_b  = b && !t && !busy;
      e_f  = f && !t && !b && !busy;
      acc  = e_t || e_b || e_f;
      sel  = e_t ? tt : (e_b ? bt : ft);
      mis  = 1'b0;
`ifdef PCL_REDIRECT_ALIGN_CHK_EN
      mis  = acc && (sel[1:0] != 2'b00);
`endif
      chk("trapAck",  {31'd0, oTrapAck},  {31'd0, e_t});
      chk("brAck",    {31'd0, oBrAck},    {31'd0, e_b});
      chk("fenceAck", {31'd0, oFenceAck}, {31'd0, e_f});
      chk("setEn",    {31'd0, oSetEn},    {31'd0, m_pend && r});
      chk("setTgt",   oSetTgt,            m_show);
      chk("flush",    {31'd0, oFlush},    {31'd0, busy || (acc && !mis)});
      chk("misalign", {31'd0, oMisalign}, {31'd0, mis});
      if (acc && mis) begin
         m_pend  = 1'b0;
         m_fleft = 0;
      end else if (acc) begin
         m_show  = sel;
         m_pend  = 1'b1;
         m_fleft = 0;
      end else if (m_pend && r) begin
         m_pend  = 1'b0;
         m_fleft = TB_FLUSH_CYC;
      end else if (m_fleft > 0) begin
         m_fleft--;
      end
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, '0, r);
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst = 1'b0;
      iTrapEn = 0; iTrapTgt = '0; iBrEn = 0; iBrTgt = '0;
      iFenceEn = 0; iFenceTgt = '0; iFetchRdy = 0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      // reset state
      idle(1, 1);

      // simultaneous requests: trap wins, 3-cycle flush window
      step(1, 32'h100, 1, 32'h200, 1, 32'h300, 1);
      chk("prio_trap_only", {31'd0, oBrAck | oFenceAck}, 32'd0);
      step(0, '0, 0, '0, 0, '0, 1);
      chk("prio_issue_tgt", oSetTgt, 32'h100);
      idle(3, 1);

      // branch stalled four cycles by fetch
      step(0, '0, 1, 32'h2000, 0, '0, 0);
      idle(4, 0);
      step(0, '0, 0, '0, 0, '0, 1);
      chk("stall_issue_tgt", oSetTgt, 32'h2000);
      idle(3, 1);

      // trap preempts a stalled branch
      step(0, '0, 1, 32'h2000, 0, '0, 0);
      idle(1, 0);
      step(1, 32'h80, 0, '0, 0, '0, 0);
      idle(1, 0);
      step(0, '0, 0, '0, 0, '0, 1);
      chk("preempt_tgt", oSetTgt, 32'h80);
      idle(3, 1);

      // trap preempts in the same cycle the old target issues
      step(0, '0, 0, '0, 1, 32'h600, 1);
      step(1, 32'h700, 0, '0, 0, '0, 1);
      idle(4, 1);

      // FLUSH_CYC=1: after issue, one FLUSH cycle; branch ignored, trap accepted
      step(0, '0, 1, 32'h1000, 0, '0, 1);
      step(0, '0, 0, '0, 0, '0, 1);
      step(0, '0, 1, 32'h3000, 0, '0, 1);
      chk("flush_br_ignored", {31'd0, oBrAck}, 32'd0);
      idle(1, 1);
      step(0, '0, 1, 32'h1100, 0, '0, 1);
      step(0, '0, 0, '0, 0, '0, 1);
      step(1, 32'h40, 1, 32'h3000, 0, '0, 1);
      chk("flush_trap_ack", {31'd0, oTrapAck}, 32'd1);
      step(0, '0, 0, '0, 0, '0, 1);
      chk("flush_trap_tgt", oSetTgt, 32'h40);
      idle(3, 1);

      // back-to-back branch after the flush completes
      step(0, '0, 1, 32'h4000, 0, '0, 1);
      idle(3, 1);
      step(0, '0, 1, 32'h5000, 0, '0, 1);
      chk("b2b_accept", {31'd0, oBrAck}, 32'd1);
      idle(3, 1);

      // unaligned target 0x1002
      step(0, '0, 1, 32'h1002, 0, '0, 1);
      idle(3, 1);

      // asynchronous reset while ISSUE
      step(0, '0, 1, 32'h9000, 0, '0, 0);
      idle(1, 0);
      @(negedge clk);
      iTrapEn = 1; iTrapTgt = 32'h44; iBrEn = 1; iBrTgt = 32'h88;
      iFetchRdy = 1;
      #2;
      rst = 1'b0;
      #1;
      chk("rst_trapAck", {31'd0, oTrapAck}, 32'd0);
      chk("rst_brAck",   {31'd0, oBrAck},   32'd0);
      chk("rst_setEn",   {31'd0, oSetEn},   32'd0);
      chk("rst_setTgt",  oSetTgt,           TB_RST_TGT);
      chk("rst_flush",   {31'd0, oFlush},   32'd0);
      chk("rst_mis",     {31'd0, oMisalign}, 32'd0);
      iTrapEn = 0; iBrEn = 0; iFetchRdy = 0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      idle(2, 1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] tt;
         logic [31:0] bt;
         logic [31:0] ft;
         tt = $urandom; bt = $urandom; ft = $urandom;
         if ($urandom_range(0, 3) != 0) tt[1:0] = 2'b00;
         if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
         if ($urandom_range(0, 3) != 0) ft[1:0] = 2'b00;
         step(($urandom_range(0, 9) == 0), tt,
              ($urandom_range(0, 3) == 0), bt,
              ($urandom_range(0, 4) == 0), ft,
              ($urandom_range(0, 9) < 7));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
